// File: rtl/fetch_unit.sv
// fetch_unit: program counter and fetch sequencer.
// Drives the instruction ROM address and picks the next PC each cycle
// (hold, halt, table jump or increment) from a small writable jump-target
// table. A start/done handshake launches a program and reports completion.
//
// Optional feature macro: FETCH_ICOUNT_EN
//   When defined, adds a 16-bit saturating output `icount` that counts every
//   non-stalled RUN edge (including the edge that enters HALT). It is cleared
//   on reset and on each accepted start.
//
// Handshake: `start` is a one-cycle request that is only accepted while the
// unit is idle or halted. There is no ready signal; the request takes effect
// on the rising edge that samples it, `fetch_valid` rises the next cycle and
// `done` falls on that same edge.
module fetch_unit #(
    parameter int PC_W       = 13,
    parameter int LUT_DEPTH  = 16,
    parameter int START_ADDR = 0,
    localparam int IDX_W     = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic             halt_op,
    input  logic             stall,
    input  logic             jump_en,
    input  logic [IDX_W-1:0] jump_idx,
    input  logic             lut_wr_en,
    input  logic [IDX_W-1:0] lut_wr_idx,
    input  logic [PC_W-1:0]  lut_wr_data,
    output logic [PC_W-1:0]  pc_o,
    output logic             fetch_valid,
    output logic             done,
`ifdef FETCH_ICOUNT_EN
    output logic [15:0]      icount,
`endif
    output logic [1:0]       dbg_state_o
);

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e          state_q;
    logic [PC_W-1:0] pc_q;
    logic            fetch_valid_q;
    logic            done_q;
    logic [PC_W-1:0] lut_q [LUT_DEPTH];

    // Next-PC candidates. The table read sees the array before any write on
    // the same edge, so a simultaneous write+jump uses the old entry.
    logic [PC_W-1:0] jump_tgt_d;
    logic [PC_W-1:0] pc_inc_d;

    assign jump_tgt_d = lut_q[jump_idx];
    assign pc_inc_d   = pc_q + PC_W'(1);

    // Sequencer FSM: state, PC and the registered status outputs move together.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= ST_IDLE;
            pc_q          <= START_PC;
            fetch_valid_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_HALT: begin
                    // Only start matters here; decoder inputs may be X.
                    if (start) begin
                        state_q       <= ST_RUN;
                        pc_q          <= START_PC;
                        fetch_valid_q <= 1'b1;
                        done_q        <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // Priority: stall > halt > jump > increment.
                    if (!stall) begin
                        if (halt_op) begin
                            // PC stays on the halt instruction.
                            state_q       <= ST_HALT;
                            fetch_valid_q <= 1'b0;
                            done_q        <= 1'b1;
                        end else if (jump_en) begin
                            pc_q <= jump_tgt_d;
                        end else begin
                            pc_q <= pc_inc_d;
                        end
                    end
                end
                default: begin
                    state_q       <= ST_IDLE;
                    pc_q          <= START_PC;
                    fetch_valid_q <= 1'b0;
                    done_q        <= 1'b0;
                end
            endcase
        end
    end

    // Jump-target table: writable in any state, cleared by reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut_q[i] <= '0;
            end
        end else if (lut_wr_en) begin
            lut_q[lut_wr_idx] <= lut_wr_data;
        end
    end

`ifdef FETCH_ICOUNT_EN
    logic [15:0] icount_q;

    // Executed-edge counter: clears on accepted start, saturates at all-ones.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            icount_q <= '0;
        end else if (state_q != ST_RUN) begin
            if (start) begin
                icount_q <= '0;
            end
        end else if (!stall && (icount_q != 16'hFFFF)) begin
            icount_q <= icount_q + 16'd1;
        end
    end

    assign icount = icount_q;
`endif

    assign pc_o        = pc_q;
    assign fetch_valid = fetch_valid_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by a random run, all
// checked against a behavioural model of the sequencing rules.
module tb_fetch_unit;

  localparam int PC_W  = 13;
  localparam int DEPTH = 16;
  localparam int IDX_W = 4;
  localparam int PC_MOD = 1 << PC_W;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic             start;
  logic             halt_op;
  logic             stall;
  logic             jump_en;
  logic [IDX_W-1:0] jump_idx;
  logic             lut_wr_en;
  logic [IDX_W-1:0] lut_wr_idx;
  logic [PC_W-1:0]  lut_wr_data;
  logic [PC_W-1:0]  pc_o;
  logic             fetch_valid;
  logic             done;
  logic [1:0]       dbg_state;
`ifdef FETCH_ICOUNT_EN
  logic [15:0]      icount;
`endif

  int total = 0;
  int bad = 0;

  // Reference model: a program counter that is either idle, running or halted.
  bit m_running;
  bit m_halted;
  int m_pc;
  int m_ic;
  int m_tab [DEPTH];

  fetch_unit #(.PC_W(PC_W), .LUT_DEPTH(DEPTH), .START_ADDR(0)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .start       (start),
    .halt_op     (halt_op),
    .stall       (stall),
    .jump_en     (jump_en),
    .jump_idx    (jump_idx),
    .lut_wr_en   (lut_wr_en),
    .lut_wr_idx  (lut_wr_idx),
    .lut_wr_data (lut_wr_data),
    .pc_o        (pc_o),
    .fetch_valid (fetch_valid),
    .done        (done),
`ifdef FETCH_ICOUNT_EN
    .icount      (icount),
`endif
    .dbg_state_o (dbg_state)
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  task automatic model_reset();
    m_running = 0;
    m_halted  = 0;
    m_pc      = 0;
    m_ic      = 0;
    for (int i = 0; i < DEPTH; i++) m_tab[i] = 0;
  endtask

  // One rising edge of the reference behaviour, using the driven inputs.
  task automatic model_edge();
    int old_target;
    old_target = m_tab[int'(jump_idx)];
    if (!m_running) begin
      if (start === 1'b1) begin
        m_running = 1;
        m_halted  = 0;
        m_pc      = 0;
        m_ic      = 0;
      end
    end else if (stall === 1'b0) begin
      if (m_ic < 65535) m_ic = m_ic + 1;
      if (halt_op === 1'b1) begin
        m_running = 0;
        m_halted  = 1;
      end else if (jump_en === 1'b1) begin
        m_pc = old_target;
      end else begin
        m_pc = (m_pc + 1) % PC_MOD;
      end
    end
    if (lut_wr_en === 1'b1) m_tab[int'(lut_wr_idx)] = int'(lut_wr_data);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_pc"}, 32'(pc_o), 32'(m_pc));
    check({tag, "_fv"}, 32'(fetch_valid), 32'(m_running));
    check({tag, "_done"}, 32'(done), 32'(m_halted));
`ifdef FETCH_ICOUNT_EN
    check({tag, "_icount"}, 32'(icount), 32'(m_ic));
`endif
  endtask

  // Driver tasks
  task automatic set_idle();
    start       = 1'b0;
    halt_op     = 1'b0;
    stall       = 1'b0;
    jump_en     = 1'b0;
    jump_idx    = '0;
    lut_wr_en   = 1'b0;
    lut_wr_idx  = '0;
    lut_wr_data = '0;
  endtask

  task automatic step(input string tag);
    @(posedge CLK);
    model_edge();
    #1;
    check_outputs(tag);
    set_idle();
  endtask

  task automatic lut_write(input int idx, input int data);
    lut_wr_en   = 1'b1;
    lut_wr_idx  = IDX_W'(idx);
    lut_wr_data = PC_W'(data);
    step("wr");
  endtask

  task automatic jump(input int idx, input string tag);
    jump_en  = 1'b1;
    jump_idx = IDX_W'(idx);
    step(tag);
  endtask

  initial begin
    set_idle();
    model_reset();
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_outputs("reset");
    check("reset_pc_const", 32'(pc_o), 32'h0);
    RST_N = 1'b1;

    // Load targets while idle; decoder inputs must be ignored here.
    lut_write(3, 'h0100);
    lut_write(5, 'h0020);
    lut_write(6, 7);
    lut_write(9, 'h1FFF);
    lut_write(10, 8);
    jump_en = 1'b1; jump_idx = 4'd3; halt_op = 1'b1;
    step("idle_ignore");

    // Start and plain increments.
    start = 1'b1;
    step("start");
    check("start_fv", 32'(fetch_valid), 32'h1);
    for (int i = 1; i <= 5; i++) step("inc");
    check("inc_pc5", 32'(pc_o), 32'h5);
    start = 1'b1;
    step("start_in_run");

    // Table jump then increment.
    jump(3, "jump3");
    check("jump3_const", 32'(pc_o), 32'h0100);
    step("after_jump");
    check("after_jump_const", 32'(pc_o), 32'h0101);

    // Stall overrides jump; self-loop jump; halt beats jump.
    jump(6, "jump6");
    for (int i = 0; i < 2; i++) begin
      stall = 1'b1; jump_en = 1'b1; jump_idx = 4'd3;
      step("stall");
    end
    check("stall_hold", 32'(pc_o), 32'h7);
    step("unstall");
    check("unstall_const", 32'(pc_o), 32'h8);
    jump(10, "self_loop");
    halt_op = 1'b1; jump_en = 1'b1; jump_idx = 4'd3;
    step("halt");
    check("halt_done", 32'(done), 32'h1);
    check("halt_pc", 32'(pc_o), 32'h8);
    for (int i = 0; i < 2; i++) begin
      halt_op = 1'bx; stall = 1'bx; jump_en = 1'bx;
      step("halt_x");
    end
    start = 1'b1;
    step("restart");
    check("restart_done", 32'(done), 32'h0);

    // Same-edge write and jump uses the old entry.
    step("pre_wr");
    lut_wr_en = 1'b1; lut_wr_idx = 4'd5; lut_wr_data = 13'h0040;
    jump(5, "wr_jump");
    check("wr_jump_old", 32'(pc_o), 32'h0020);
    jump(5, "jump_new");
    check("jump_new_const", 32'(pc_o), 32'h0040);

    // Wrap at the top of the address space.
    jump(9, "jump_top");
    step("wrap");
    check("wrap_const", 32'(pc_o), 32'h0);
    step("post_wrap");

    // Asynchronous reset mid-run, no clock edge needed.
    #3;
    RST_N = 1'b0;
    model_reset();
    #1;
    check_outputs("async_rst");
    @(posedge CLK);
    #1;
    check_outputs("rst_hold");
    RST_N = 1'b1;

    // Table was cleared by reset.
    start = 1'b1;
    step("start2");
    jump(3, "cleared_jump");
    check("cleared_const", 32'(pc_o), 32'h0);
    halt_op = 1'b1;
    step("halt2");

    // Instruction counter: 8 non-stalled edges incl. the halt edge.
    start = 1'b1;
    step("ic_start");
    for (int i = 0; i < 6; i++) step("ic_run");
    for (int i = 0; i < 2; i++) begin
      stall = 1'b1;
      step("ic_stall");
    end
    step("ic_run2");
    halt_op = 1'b1;
    step("ic_halt");
`ifdef FETCH_ICOUNT_EN
    check("icount_8", 32'(icount), 32'd8);
`endif
    step("ic_hold");
    start = 1'b1;
    step("ic_restart");
`ifdef FETCH_ICOUNT_EN
    check("icount_clr", 32'(icount), 32'd0);
`endif

    // Random run against the model.
    for (int n = 0; n < 400; n++) begin
      start       = ($urandom_range(0, 3) == 0);
      halt_op     = ($urandom_range(0, 24) == 0);
      stall       = ($urandom_range(0, 4) == 0);
      jump_en     = ($urandom_range(0, 3) == 0);
      jump_idx    = IDX_W'($urandom_range(0, DEPTH - 1));
      lut_wr_en   = ($urandom_range(0, 3) == 0);
      lut_wr_idx  = IDX_W'($urandom_range(0, DEPTH - 1));
      lut_wr_data = PC_W'($urandom_range(0, PC_MOD - 1));
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
